// File: rtl/facto_pkg.sv
// Shared constants for the factorial accelerator: register map, status bits
// and controller state encoding.
package facto_pkg;

  localparam int unsigned OFS_W = 6;

  localparam logic [OFS_W-1:0] OFS_START   = 6'h00;
  localparam logic [OFS_W-1:0] OFS_CLEAR   = 6'h08;
  localparam logic [OFS_W-1:0] OFS_STATUS  = 6'h10;
  localparam logic [OFS_W-1:0] OFS_INTREN  = 6'h18;
  localparam logic [OFS_W-1:0] OFS_OPERAND = 6'h20;
  localparam logic [OFS_W-1:0] OFS_RES_H   = 6'h28;
  localparam logic [OFS_W-1:0] OFS_RES_L   = 6'h30;

  // Registers sit on 8-byte steps; only the word index is decoded.
  localparam logic [2:0] IDX_START   = OFS_START[5:3];
  localparam logic [2:0] IDX_CLEAR   = OFS_CLEAR[5:3];
  localparam logic [2:0] IDX_STATUS  = OFS_STATUS[5:3];
  localparam logic [2:0] IDX_INTREN  = OFS_INTREN[5:3];
  localparam logic [2:0] IDX_OPERAND = OFS_OPERAND[5:3];
  localparam logic [2:0] IDX_RES_H   = OFS_RES_H[5:3];
  localparam logic [2:0] IDX_RES_L   = OFS_RES_L[5:3];

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_OVF  = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_DEC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/facto_mul.sv
// Iterative shift-add multiplier: MUL_BITS multiplier bits per cycle, result
// ready MUL_CYC cycles after start; ovf_c flags product bits beyond 2*DATA_W.
module facto_mul #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2*DATA_W-1:0]   mcand,
  input  logic [OP_W-1:0]       mplier,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  ovf_c,
  output logic                  done_c
);

  localparam int unsigned RW      = 2 * DATA_W;
  localparam int unsigned PW      = RW + OP_W;
  localparam int unsigned MUL_CYC = OP_W / MUL_BITS;
  localparam int unsigned CW      = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  logic [PW-1:0]   acc;
  logic [PW-1:0]   mc_sh;
  logic [OP_W-1:0] mp_sh;
  logic [CW-1:0]   cnt;
  logic            run;
  logic [PW-1:0]   partial_c;

  assign partial_c = mc_sh * PW'(mp_sh[MUL_BITS-1:0]);
  assign done_c    = run && (cnt == CW'(MUL_CYC - 1));
  assign prod      = acc[RW-1:0];
  assign ovf_c     = |acc[PW-1:RW];

  // Flush abandons any product in flight so a cleared job leaves no residue.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      acc   <= '0;
      mc_sh <= '0;
      mp_sh <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      mc_sh <= PW'(mcand);
      mp_sh <= mplier;
      cnt   <= '0;
      run   <= 1'b1;
    end else if (run) begin
      acc   <= acc + partial_c;
      mc_sh <= mc_sh << MUL_BITS;
      mp_sh <= mp_sh >> MUL_BITS;
      cnt   <= cnt + CW'(1);
      if (done_c) run <= 1'b0;
    end
  end

endmodule

// File: rtl/facto_core_mc.sv
// Memory-mapped factorial accelerator: computes operand! with a shared
// multi-cycle multiplier; sticky overflow, abort-on-clear, busy write lock.
module facto_core_mc
  import facto_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = 16'h7000,
  parameter int unsigned           DATA_W    = 64,
  parameter int unsigned           OP_W      = 8,
  parameter int unsigned           MUL_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  localparam int unsigned RW = 2 * DATA_W;

  state_t          state, state_nx;
  logic [OP_W-1:0] operand;
  logic [OP_W-1:0] k;
  logic            intr_en;
  logic            done;
  logic            busy;
  logic            overflow;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   result;

  logic            hit_c, wr_c, rd_c, start_c, clear_c;
  logic [2:0]      idx_c;
  logic            mul_start_c;
  logic [RW-1:0]   mul_mcand_c;
  logic [OP_W-1:0] mul_mplier_c;
  logic [RW-1:0]   mul_prod;
  logic            mul_ovf_c, mul_done_c;
  logic            unused_bits_c;

  assign hit_c   = s_sel && (s_addr[ADDR_W-1:6] == BASE_ADDR[ADDR_W-1:6]);
  assign wr_c    = hit_c && s_wr;
  assign rd_c    = hit_c && !s_wr;
  assign idx_c   = s_addr[5:3];
  assign start_c = wr_c && (idx_c == IDX_START) && s_din[0] && !busy;
  assign clear_c = wr_c && (idx_c == IDX_CLEAR) && s_din[0];

  assign interrupt     = done && intr_en;
  assign unused_bits_c = ^{s_din[DATA_W-1:OP_W], s_addr[2:0]};

  facto_mul #(
    .DATA_W   (DATA_W),
    .OP_W     (OP_W),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start_c),
    .flush   (clear_c),
    .mcand   (mul_mcand_c),
    .mplier  (mul_mplier_c),
    .prod    (mul_prod),
    .ovf_c   (mul_ovf_c),
    .done_c  (mul_done_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // In DEC the fresh product is still in the multiplier, so it feeds the next pass directly.
  always_comb begin
    state_nx     = state;
    mul_start_c  = 1'b0;
    mul_mcand_c  = mul_prod;
    mul_mplier_c = k - OP_W'(1);
    case (state)
      S_IDLE: if (start_c) state_nx = S_LOAD;
      S_LOAD: begin
        if (operand <= OP_W'(1)) begin
          state_nx = S_DONE;
        end else begin
          state_nx     = S_MUL;
          mul_start_c  = 1'b1;
          mul_mcand_c  = RW'(1);
          mul_mplier_c = operand;
        end
      end
      S_MUL: if (mul_done_c) state_nx = S_DEC;
      S_DEC: begin
        if (k == OP_W'(2)) begin
          state_nx = S_DONE;
        end else begin
          state_nx    = S_MUL;
          mul_start_c = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (clear_c) begin
      state_nx    = S_IDLE;
      mul_start_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      operand  <= '0;
      k        <= '0;
      intr_en  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      result   <= '0;
    end else begin
      if (wr_c && (idx_c == IDX_OPERAND) && !busy) operand <= s_din[OP_W-1:0];
      if (wr_c && (idx_c == IDX_INTREN) && !busy)  intr_en <= s_din[0];
      if (clear_c) begin
        done     <= 1'b0;
        busy     <= 1'b0;
        overflow <= 1'b0;
        result   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_c) begin
              busy     <= 1'b1;
              done     <= 1'b0;
              overflow <= 1'b0;
            end
          end
          S_LOAD: begin
            acc <= RW'(1);
            k   <= operand;
          end
          S_DEC: begin
            acc      <= mul_prod;
            overflow <= overflow | mul_ovf_c;
            k        <= k - OP_W'(1);
          end
          S_DONE: begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux: combinational, zero unless this slave is selected for a read.
  always_comb begin
    s_dout = '0;
    if (rd_c) begin
      case (idx_c)
        IDX_STATUS: begin
          s_dout[ST_DONE] = done;
          s_dout[ST_BUSY] = busy;
          s_dout[ST_OVF]  = overflow;
        end
        IDX_INTREN:  s_dout = DATA_W'(intr_en);
        IDX_OPERAND: s_dout = DATA_W'(operand);
        IDX_RES_H:   s_dout = result[RW-1:DATA_W];
        IDX_RES_L:   s_dout = result[DATA_W-1:0];
        default:     s_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_facto_core_mc.sv
// Self-checking bench for facto_core_mc: vector table, randomized operands
// against a plain-arithmetic factorial model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_facto_core_mc;

  localparam logic [15:0] BASE = 16'h7000;
  localparam logic [5:0] A_START = 6'h00, A_CLEAR = 6'h08, A_STATUS = 6'h10,
                         A_INTREN = 6'h18, A_OPERAND = 6'h20, A_RES_H = 6'h28,
                         A_RES_L = 6'h30;
  localparam int MUL_CYC = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int errors = 0;
  int checks = 0;

  facto_core_mc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  always #10 clk = ~clk;

  typedef struct {
    int           n;
    logic         ien;
    logic [127:0] res;
    logic         ovf;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] ofs, input logic [63:0] data);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = BASE + 16'(ofs);
    s_din  = data;
    @(posedge clk);
    #1;
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_din  = '0;
  endtask

  task automatic bus_read(input logic [5:0] ofs, output logic [63:0] data);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = BASE + 16'(ofs);
    #1;
    data   = s_dout;
    s_sel  = 1'b0;
  endtask

  // N! truncated to 128 bits; overflow once any partial product needs more.
  function automatic void fact_model(input int n, output logic [127:0] res, output logic ovf);
    logic [255:0] t;
    res = 128'd1;
    ovf = 1'b0;
    for (int i = 2; i <= n; i++) begin
      t = {128'd0, res} * 256'(i);
      if (t[255:128] != '0) ovf = 1'b1;
      res = t[127:0];
    end
  endfunction

  function automatic int lat_model(input int n);
    return (n <= 1) ? 2 : 2 + (n - 1) * (MUL_CYC + 1);
  endfunction

  // Starts a job, measures START-edge-to-done latency, then checks the results.
  task automatic run_case(input vec_t v);
    logic [63:0] d, rh, rl;
    int lat;
    bus_write(A_CLEAR, 64'd1);
    bus_write(A_OPERAND, 64'(v.n));
    bus_write(A_INTREN, 64'(v.ien));
    bus_write(A_START, 64'd1);
    lat = 0;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk);
      #1;
      bus_read(A_STATUS, d);
      if (d[0]) begin
        lat = c;
        break;
      end
    end
    check($sformatf("latency n=%0d", v.n), 128'(lat), 128'(v.lat));
    bus_read(A_STATUS, d);
    bus_read(A_RES_H, rh);
    bus_read(A_RES_L, rl);
    check($sformatf("status n=%0d", v.n), 128'(d), {125'd0, v.ovf, 2'b01});
    check($sformatf("result n=%0d", v.n), {rh, rl}, v.res);
    check($sformatf("interrupt n=%0d", v.n), 128'(interrupt), 128'(v.ien));
  endtask

  vec_t        tbl[8];
  vec_t        v;
  logic [63:0] d;
  logic [127:0] m_res;
  logic         m_ovf;

  initial begin
    reset_n = 1'b0;
    s_sel   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    repeat (2) @(posedge clk);
    #1;
    bus_read(A_STATUS, d);  check("reset status", 128'(d), 128'd0);
    bus_read(A_OPERAND, d); check("reset operand", 128'(d), 128'd0);
    bus_read(A_RES_L, d);   check("reset res_l", 128'(d), 128'd0);
    check("reset interrupt", 128'(interrupt), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Vector table; 34!/35! come from the model, overflow bits are fixed here.
    tbl[0] = '{5,   1'b1, 128'd120,      1'b0, 38};
    tbl[1] = '{10,  1'b1, 128'h375F00,   1'b0, 83};
    tbl[2] = '{0,   1'b0, 128'd1,        1'b0, 2};
    tbl[3] = '{1,   1'b0, 128'd1,        1'b0, 2};
    tbl[4] = '{2,   1'b1, 128'd2,        1'b0, 11};
    fact_model(34, m_res, m_ovf);
    tbl[5] = '{34,  1'b1, m_res,         1'b0, lat_model(34)};
    fact_model(35, m_res, m_ovf);
    tbl[6] = '{35,  1'b0, m_res,         1'b1, lat_model(35)};
    tbl[7] = '{255, 1'b1, 128'd0,        1'b1, 2288};
    for (int i = 0; i < 8; i++) run_case(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      v.n   = int'($urandom_range(0, 40));
      v.ien = 1'($urandom_range(0, 1));
      fact_model(v.n, v.res, v.ovf);
      v.lat = lat_model(v.n);
      run_case(v);
    end

    // Dropping intr_en while done drops interrupt; a START with bit0=0 is a no-op.
    v = '{3, 1'b1, 128'd6, 1'b0, 20};
    run_case(v);
    bus_write(A_INTREN, 64'd0);
    check("intr_en drop", 128'(interrupt), 128'd0);
    bus_write(A_START, 64'd2);
    repeat (3) @(posedge clk);
    #1;
    bus_read(A_STATUS, d);
    check("start bit0=0", 128'(d), 128'd1);

    // Writes ignored while busy, then abort by CLEAR.
    bus_write(A_OPERAND, 64'd20);
    bus_write(A_START, 64'd1);
    repeat (30) @(posedge clk);
    bus_write(A_OPERAND, 64'd3);
    bus_write(A_START, 64'd1);
    bus_write(A_INTREN, 64'd1);
    bus_read(A_OPERAND, d); check("busy operand lock", 128'(d), 128'd20);
    bus_read(A_STATUS, d);  check("busy status", 128'(d), 128'd2);
    bus_read(A_INTREN, d);  check("busy intren lock", 128'(d), 128'd0);
    bus_read(A_RES_L, d);   check("result held while busy", 128'(d), 128'd6);
    repeat (10) @(posedge clk);
    bus_write(A_CLEAR, 64'd1);
    bus_read(A_STATUS, d);  check("clear status", 128'(d), 128'd0);
    bus_read(A_RES_H, d);   check("clear res_h", 128'(d), 128'd0);
    bus_read(A_RES_L, d);   check("clear res_l", 128'(d), 128'd0);
    bus_read(A_OPERAND, d); check("clear keeps operand", 128'(d), 128'd20);
    check("clear interrupt", 128'(interrupt), 128'd0);
    fact_model(20, v.res, v.ovf);
    v.n = 20; v.ien = 1'b1; v.lat = lat_model(20);
    run_case(v);

    // Synchronous reset in the middle of a job.
    bus_write(A_OPERAND, 64'd12);
    bus_write(A_START, 64'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    bus_read(A_STATUS, d);  check("midreset status", 128'(d), 128'd0);
    bus_read(A_OPERAND, d); check("midreset operand", 128'(d), 128'd0);
    bus_read(A_INTREN, d);  check("midreset intren", 128'(d), 128'd0);
    bus_read(A_RES_L, d);   check("midreset res_l", 128'(d), 128'd0);
    check("midreset interrupt", 128'(interrupt), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    v = '{6, 1'b1, 128'd720, 1'b0, 47};
    run_case(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
